// File: rtl/adc_filter_pkg.sv
// Shared definitions for the ADC moving-average filter: sample width, FSM states
// and the default window depth.
package adc_filter_pkg;
  localparam int ADC_W          = 12;
  localparam int LOG2_DEPTH_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/adc_sample_ring.sv
// Ring buffer of the last 2^LOG2_DEPTH samples; the read port always shows the
// entry about to be overwritten, which is the oldest one once the window is full.
module adc_sample_ring
  import adc_filter_pkg::*;
#(
  parameter int LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [ADC_W-1:0] i_wdata,
  output logic [ADC_W-1:0] o_oldest
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [ADC_W-1:0]      r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
    end
  end

  // Storage needs no reset: entries are only read back after being rewritten.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_oldest = r_mem[r_wr_ptr];
endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average ADC filter with FILL/RUN FSM and running sum.
// Optional peak-hold of the average is enabled by defining ADC_PEAK_HOLD_EN.
module adc_avg_filter
  import adc_filter_pkg::*;
#(
  parameter int LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ADC_W-1:0] i_adc_data,
  input  logic             i_adc_valid,
  input  logic             i_clr,
  output logic [ADC_W-1:0] o_v_avg,
  output logic             o_avg_valid,
  output logic [ADC_W-1:0] o_v_peak,
  output logic             o_filled
);
  localparam int SUM_W = ADC_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] FILL_LAST = LOG2_DEPTH'((1 << LOG2_DEPTH) - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [SUM_W-1:0]      r_sum;
  logic [SUM_W-1:0]      w_sum_next;
  logic [LOG2_DEPTH-1:0] r_fill_cnt;
  logic [LOG2_DEPTH-1:0] w_fill_next;
  logic [ADC_W-1:0]      r_avg;
  logic [ADC_W-1:0]      w_avg_next;
  logic                  r_avg_valid;
  logic                  w_pulse;
  logic                  w_accept;
  logic [ADC_W-1:0]      w_oldest;

  assign w_accept   = i_adc_valid & ~i_clr;
  assign w_avg_next = w_sum_next[SUM_W-1:LOG2_DEPTH];

  adc_sample_ring #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clr),
    .i_we    (w_accept),
    .i_wdata (i_adc_data),
    .o_oldest(w_oldest)
  );

  always_comb begin
    w_state_next = r_state;
    w_sum_next   = r_sum;
    w_fill_next  = r_fill_cnt;
    w_pulse      = 1'b0;
    if (i_clr) begin
      w_state_next = FILL;
      w_sum_next   = '0;
      w_fill_next  = '0;
    end else if (i_adc_valid) begin
      case (r_state)
        FILL: begin
          w_sum_next  = r_sum + {{LOG2_DEPTH{1'b0}}, i_adc_data};
          w_fill_next = r_fill_cnt + LOG2_DEPTH'(1);
          if (r_fill_cnt == FILL_LAST) begin
            w_state_next = RUN;
            w_pulse      = 1'b1;
          end else begin
            w_state_next = FILL;
          end
        end
        RUN: begin
          // Intermediate may wrap modulo 2^SUM_W; the final window sum always fits.
          w_sum_next = r_sum + {{LOG2_DEPTH{1'b0}}, i_adc_data}
                             - {{LOG2_DEPTH{1'b0}}, w_oldest};
          w_pulse    = 1'b1;
        end
        default: begin
          w_state_next = FILL;
          w_sum_next   = '0;
          w_fill_next  = '0;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FILL;
      r_sum       <= '0;
      r_fill_cnt  <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sum       <= w_sum_next;
      r_fill_cnt  <= w_fill_next;
      r_avg_valid <= w_pulse;
      if (i_clr) begin
        r_avg <= '0;
      end else if (w_pulse) begin
        r_avg <= w_avg_next;
      end
    end
  end

`ifdef ADC_PEAK_HOLD_EN
  logic [ADC_W-1:0] r_peak;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_peak <= '0;
    end else if (i_clr) begin
      r_peak <= '0;
    end else if (w_pulse && (w_avg_next > r_peak)) begin
      r_peak <= w_avg_next;
    end
  end

  assign o_v_peak = r_peak;
`else
  assign o_v_peak = '0;
`endif

  assign o_v_avg     = r_avg;
  assign o_avg_valid = r_avg_valid;
  assign o_filled    = (r_state == RUN);
endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter: directed scenarios plus random traffic
// against a queue-based window-mean reference model.
module tb_adc_avg_filter;
  import adc_filter_pkg::*;

  localparam int L     = 3;
  localparam int DEPTH = 1 << L;
`ifdef ADC_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = 12'h000;
  logic        adc_valid = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] v_avg;
  logic        avg_valid;
  logic [11:0] v_peak;
  logic        filled;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] win[$];
  logic [11:0] m_avg;
  logic [11:0] m_peak;
  logic        m_valid;
  logic        m_filled;

  adc_avg_filter #(.LOG2_DEPTH(L)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_adc_data (adc_data),
    .i_adc_valid(adc_valid),
    .i_clr      (clr),
    .o_v_avg    (v_avg),
    .o_avg_valid(avg_valid),
    .o_v_peak   (v_peak),
    .o_filled   (filled)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    win.delete();
    m_avg    = 12'h000;
    m_peak   = 12'h000;
    m_valid  = 1'b0;
    m_filled = 1'b0;
  endfunction

  // Reference: mean of the last DEPTH accepted samples, issued once the window holds DEPTH.
  function automatic void model_step(input logic v, input logic [11:0] d, input logic c);
    int s;
    m_valid = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      win.push_back(d);
      if (win.size() > DEPTH) void'(win.pop_front());
      if (win.size() == DEPTH) begin
        s = 0;
        foreach (win[i]) s += int'(win[i]);
        m_avg   = 12'(s / DEPTH);
        m_valid = 1'b1;
        if (PEAK_EN && (m_avg > m_peak)) m_peak = m_avg;
      end
    end
    m_filled = (win.size() == DEPTH);
  endfunction

  task automatic cycle(input logic v, input logic [11:0] d, input logic c);
    @(negedge clk);
    adc_valid = v;
    adc_data  = d;
    clr       = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({avg_valid, filled, v_avg, v_peak} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset: got v=%b f=%b avg=%h pk=%h, want all zero", avg_valid, filled, v_avg, v_peak);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_const();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 12'h800, 1'b0);
      n_checks++;
      if ({avg_valid, filled, v_avg, v_peak} !== {m_valid, m_filled, m_avg, m_peak}) begin
        n_fail++;
        $display("FAIL fill_const s%0d: got v=%b f=%b avg=%h pk=%h, want v=%b f=%b avg=%h pk=%h",
                 i, avg_valid, filled, v_avg, v_peak, m_valid, m_filled, m_avg, m_peak);
      end
      cycle(1'b0, 12'h000, 1'b0);
    end
    cycle(1'b0, 12'h000, 1'b0);
    n_checks++;
    if (v_avg !== 12'h800 || filled !== 1'b1 || avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_const_hold: got avg=%h f=%b v=%b, want avg=800 f=1 v=0", v_avg, filled, avg_valid);
    end
  endtask

  task automatic test_step();
    logic [11:0] want;
    cycle(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 12'h000, 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1'b1, 12'hFFF, 1'b0);
      want = 12'((k * 4095) / DEPTH);
      n_checks++;
      if (avg_valid !== 1'b1 || v_avg !== want || v_avg !== m_avg) begin
        n_fail++;
        $display("FAIL step k%0d: got v=%b avg=%h, want v=1 avg=%h", k, avg_valid, v_avg, want);
      end
    end
  endtask

  task automatic test_clr_priority();
    cycle(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 12'h400, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'hC00, 1'b0);
    cycle(1'b1, 12'hFFF, 1'b1);
    n_checks++;
    if ({avg_valid, filled, v_avg, v_peak} !== 26'h0) begin
      n_fail++;
      $display("FAIL clr_priority: got v=%b f=%b avg=%h pk=%h, want all zero", avg_valid, filled, v_avg, v_peak);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 12'h123, 1'b0);
      n_checks++;
      if ({avg_valid, filled, v_avg, v_peak} !== {m_valid, m_filled, m_avg, m_peak}) begin
        n_fail++;
        $display("FAIL clr_refill s%0d: got v=%b f=%b avg=%h pk=%h, want v=%b f=%b avg=%h pk=%h",
                 i, avg_valid, filled, v_avg, v_peak, m_valid, m_filled, m_avg, m_peak);
      end
    end
  endtask

  task automatic test_peak();
    logic [11:0] seq [3];
    logic [11:0] want [3];
    seq  = '{12'h300, 12'h500, 12'h200};
    want = '{12'h300, 12'h500, 12'h500};
    cycle(1'b0, 12'h000, 1'b1);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, seq[w], 1'b0);
      cycle(1'b0, 12'h000, 1'b0);
      n_checks++;
      if (v_avg !== seq[w] || v_peak !== (PEAK_EN ? want[w] : 12'h000)) begin
        n_fail++;
        $display("FAIL peak w%0d: got avg=%h pk=%h, want avg=%h pk=%h",
                 w, v_avg, v_peak, seq[w], PEAK_EN ? want[w] : 12'h000);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 12'h777, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'h111, 1'b0);
    cycle(1'b0, 12'h000, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({avg_valid, filled, v_avg, v_peak} !== 26'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b f=%b avg=%h pk=%h, want all zero", avg_valid, filled, v_avg, v_peak);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 12'h222, 1'b0);
      n_checks++;
      if (avg_valid !== (i == DEPTH - 1) || v_avg !== ((i == DEPTH - 1) ? 12'h222 : 12'h000)) begin
        n_fail++;
        $display("FAIL post_reset s%0d: got v=%b avg=%h, want v=%b avg=%h",
                 i, avg_valid, v_avg, (i == DEPTH - 1), (i == DEPTH - 1) ? 12'h222 : 12'h000);
      end
    end
  endtask

  task automatic test_trunc();
    cycle(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 12'h001, 1'b0);
    cycle(1'b1, 12'h002, 1'b0);
    n_checks++;
    if (avg_valid !== 1'b1 || v_avg !== 12'h001) begin
      n_fail++;
      $display("FAIL trunc: got v=%b avg=%h, want v=1 avg=001", avg_valid, v_avg);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        c;
    logic [11:0] d;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      d = 12'($urandom_range(0, 4095));
      cycle(v, d, c);
      n_checks++;
      if ({avg_valid, filled, v_avg, v_peak} !== {m_valid, m_filled, m_avg, m_peak}) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%b f=%b avg=%h pk=%h, want v=%b f=%b avg=%h pk=%h",
                 i, avg_valid, filled, v_avg, v_peak, m_valid, m_filled, m_avg, m_peak);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_const();
    test_step();
    test_clr_priority();
    test_peak();
    test_async_reset();
    test_trunc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 Parameter: LOG2_DEPTH, 3, log2 of the averaging window depth (DEPTH = 2^LOG2_DEPTH); legal range 1..5.
REQ-002 CLK  input  1  system clock (pll_clk domain); all state changes on its rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-high.
REQ-004 ADC_DATA  input  12  raw ADC conversion result; valid only when ADC_VALID=1.
REQ-005 ADC_VALID  input  1  one-cycle strobe marking a new ADC_DATA sample (ADC DRDY).
REQ-006 CLR  input  1  synchronous clear of window, sum, peak and state; active-high.
REQ-007 V_AVG  output  12  filtered voltage (window mean), held between updates.
REQ-008 AVG_VALID  output  1  one-cycle pulse when V_AVG updates.
REQ-009 V_PEAK  output  12  largest V_AVG since reset/CLR (peak-hold feature).
REQ-010 FILLED  output  1  high while state is RUN.

Function
REQ-011 Block SHALL implement a two-state FSM: FILL (window not yet full) and RUN (window full).
REQ-012 In FILL, each accepted sample SHALL be written to the ring buffer, added to the sum, and increment the fill counter; no AVG_VALID is issued.
REQ-013 On acceptance of the DEPTH-th sample, FSM SHALL move to RUN, and on the following cycle AVG_VALID=1 and V_AVG=sum>>LOG2_DEPTH.
REQ-014 In RUN, each accepted sample SHALL replace the oldest buffer entry; sum_next = sum + new - oldest; AVG_VALID pulses exactly one cycle after ADC_VALID.
REQ-015 Sum register SHALL be 12+LOG2_DEPTH bits wide; no overflow or saturation is possible, and truncating division (shift) is used.
REQ-016 Ring write pointer SHALL be LOG2_DEPTH bits and wrap from DEPTH-1 to 0 without a gap.
REQ-017 Back-to-back ADC_VALID on consecutive cycles SHALL be accepted at full rate (one sample per cycle, no drops).
REQ-018 CLR=1 SHALL take priority over ADC_VALID in the same cycle; that sample is discarded.
REQ-019 CLR SHALL zero the sum, pointer, fill counter, V_AVG and V_PEAK, deassert AVG_VALID, and return the FSM to FILL on the next edge.
REQ-020 ADC_VALID=0 SHALL leave all state and V_AVG unchanged.

Reset
REQ-021 While RST=1: FSM=FILL, sum=0, pointer=0, fill count=0, buffer contents don't-care, V_AVG=0, AVG_VALID=0, V_PEAK=0, FILLED=0.
REQ-022 RST asserted mid-window SHALL discard all partial data; the first post-reset average requires DEPTH fresh samples.

Configuration
REQ-023 Macro ADC_PEAK_HOLD_EN defined: on each AVG_VALID, V_PEAK SHALL load V_AVG if V_AVG > V_PEAK (strict compare), using the value presented with that pulse.
REQ-024 Macro ADC_PEAK_HOLD_EN undefined: V_PEAK SHALL be constant 0 and no peak register is synthesised.

Structure
REQ-025 Shared package adc_filter_pkg SHALL hold ADC_W=12, the FSM state enumeration (FILL, RUN), and the default LOG2_DEPTH.
REQ-026 Ring storage SHALL be a sub-module adc_sample_ring (write-enable, wrap pointer, oldest-entry read port); FSM, sum and peak logic live in the top.

Verification
REQ-027 Reset, then 8 samples of 0x800 (LOG2_DEPTH=3) -> AVG_VALID first pulses one cycle after the 8th strobe, V_AVG=0x800, FILLED=1; no pulse earlier.
REQ-028 Full window of 0x000, then 8 samples of 0xFFF on consecutive cycles -> V_AVG steps 0x1FF,0x3FF,...,0xFFF; sum never wraps.
REQ-029 After window at 0x400, 4 samples of 0xC00, then CLR asserted together with ADC_VALID -> sample dropped, V_AVG=0, V_PEAK=0, FILLED=0; 8 new samples required before next pulse.
REQ-030 Peak-hold enabled: averages 0x300, 0x500, 0x200 -> V_PEAK 0x300, 0x500, 0x500; disabled build -> V_PEAK stays 0.
REQ-031 RST pulsed after 5 of 8 samples -> all outputs 0 immediately (asynchronous); next AVG_VALID only after 8 further samples.
REQ-032 Samples 0x001 x7 then 0x002 -> V_AVG=0x001 (truncation of 9/8).
